// File: rtl/rs_inorder_entries_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rs_inorder_entries_pkg
// Purpose  : Shared constants and types for the in-order reservation station
//            entry storage.
// Revision : 1.0 - initial release
// ============================================================================
package rs_inorder_entries_pkg;

  // Default datapath sizes shared by the RS entry storage and its users.
  localparam int TAG_WIDTH    = 6;
  localparam int DATA_WIDTH   = 32;
  localparam int OP_WIDTH     = 16;
  localparam int ENT_NUM      = 2;
  localparam int ENT_SEL      = 1;
  // Number of dispatch ports written per cycle.
  localparam int DP_NUM_WIDTH = 2;

  // Where an operand slot takes its next value from.
  typedef enum logic [1:0] {
    SRC_HOLD = 2'd0,
    SRC_DISP = 2'd1,
    SRC_CDB1 = 2'd2,
    SRC_CDB2 = 2'd3
  } src_sel_e;

endpackage
`default_nettype wire

// File: rtl/rs_src_slot.sv
`default_nettype none
// ============================================================================
// Module   : rs_src_slot
// Purpose  : One source operand of an RS entry: ready flag, producer tag and
//            value. Loads at dispatch (with same-cycle CDB bypass) and wakes
//            up from either of two CDB ports, port 1 taking precedence.
// Revision : 1.0 - initial release
// ============================================================================
module rs_src_slot
  import rs_inorder_entries_pkg::*;
#(
  parameter int DATA_WIDTH = rs_inorder_entries_pkg::DATA_WIDTH,
  parameter int TAG_WIDTH  = rs_inorder_entries_pkg::TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_kill,
  input  logic                  i_clr,
  input  logic                  i_load,
  input  logic                  i_busy,
  input  logic                  i_ld_rdy,
  input  logic [TAG_WIDTH-1:0]  i_ld_tag,
  input  logic [DATA_WIDTH-1:0] i_ld_val,
  input  logic                  i_cdb_vld_1,
  input  logic [TAG_WIDTH-1:0]  i_cdb_tag_1,
  input  logic [DATA_WIDTH-1:0] i_cdb_val_1,
  input  logic                  i_cdb_vld_2,
  input  logic [TAG_WIDTH-1:0]  i_cdb_tag_2,
  input  logic [DATA_WIDTH-1:0] i_cdb_val_2,
  output logic                  o_rdy,
  output logic [DATA_WIDTH-1:0] o_val
);

  logic                  r_rdy;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [DATA_WIDTH-1:0] r_val;

  logic [TAG_WIDTH-1:0]  w_cmp_tag;
  logic                  w_hit_1;
  logic                  w_hit_2;
  logic                  w_listen;
  src_sel_e              w_sel;

  // Pick the next operand source: dispatch data, a CDB capture, or hold.
  // While loading, the incoming tag is compared so a broadcast in the same
  // cycle is not missed.
  always_comb begin
    w_cmp_tag = i_load ? i_ld_tag : r_tag;
    w_hit_1   = i_cdb_vld_1 && (i_cdb_tag_1 == w_cmp_tag);
    w_hit_2   = i_cdb_vld_2 && (i_cdb_tag_2 == w_cmp_tag);
    w_listen  = i_load ? !i_ld_rdy : (i_busy && !r_rdy);
    w_sel     = SRC_HOLD;
    if (i_load && i_ld_rdy) begin
      w_sel = SRC_DISP;
    end else if (w_listen && w_hit_1) begin
      w_sel = SRC_CDB1;
    end else if (w_listen && w_hit_2) begin
      w_sel = SRC_CDB2;
    end else if (i_load) begin
      w_sel = SRC_DISP;
    end
  end

  // Operand state: kill wins, then load/wakeup, then issue clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy <= 1'b0;
      r_tag <= '0;
      r_val <= '0;
    end else if (i_kill) begin
      r_rdy <= 1'b0;
    end else begin
      if (i_load) begin
        r_tag <= i_ld_tag;
      end
      case (w_sel)
        SRC_DISP: begin
          r_rdy <= i_ld_rdy;
          r_val <= i_ld_val;
        end
        SRC_CDB1: begin
          r_rdy <= 1'b1;
          r_val <= i_cdb_val_1;
        end
        SRC_CDB2: begin
          r_rdy <= 1'b1;
          r_val <= i_cdb_val_2;
        end
        default: begin
          if (i_clr) begin
            r_rdy <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_rdy = r_rdy;
  assign o_val = r_val;

endmodule
`default_nettype wire

// File: rtl/rs_inorder_entries.sv
`default_nettype none
// ============================================================================
// Module   : rs_inorder_entries
// Purpose  : Entry storage of an in-order reservation station. Two dispatch
//            writes per cycle into allocator-chosen slots, dual-CDB operand
//            wakeup, busy/ready status export and a zero-latency issue read.
// Revision : 1.0 - initial release
// ============================================================================
module rs_inorder_entries
  import rs_inorder_entries_pkg::*;
#(
  parameter int ENT_NUM    = rs_inorder_entries_pkg::ENT_NUM,
  parameter int ENT_SEL    = rs_inorder_entries_pkg::ENT_SEL,
  parameter int DATA_WIDTH = rs_inorder_entries_pkg::DATA_WIDTH,
  parameter int TAG_WIDTH  = rs_inorder_entries_pkg::TAG_WIDTH,
  parameter int OP_WIDTH   = rs_inorder_entries_pkg::OP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_kill,
  input  logic                  i_we_1,
  input  logic                  i_we_2,
  input  logic [ENT_SEL-1:0]    i_wsel_1,
  input  logic [ENT_SEL-1:0]    i_wsel_2,
  input  logic [OP_WIDTH-1:0]   i_op_1,
  input  logic [OP_WIDTH-1:0]   i_op_2,
  input  logic                  i_srca_rdy_1,
  input  logic                  i_srca_rdy_2,
  input  logic                  i_srcb_rdy_1,
  input  logic                  i_srcb_rdy_2,
  input  logic [DATA_WIDTH-1:0] i_srca_val_1,
  input  logic [DATA_WIDTH-1:0] i_srca_val_2,
  input  logic [DATA_WIDTH-1:0] i_srcb_val_1,
  input  logic [DATA_WIDTH-1:0] i_srcb_val_2,
  input  logic [TAG_WIDTH-1:0]  i_srca_tag_1,
  input  logic [TAG_WIDTH-1:0]  i_srca_tag_2,
  input  logic [TAG_WIDTH-1:0]  i_srcb_tag_1,
  input  logic [TAG_WIDTH-1:0]  i_srcb_tag_2,
  input  logic                  i_cdb_vld_1,
  input  logic                  i_cdb_vld_2,
  input  logic [TAG_WIDTH-1:0]  i_cdb_tag_1,
  input  logic [TAG_WIDTH-1:0]  i_cdb_tag_2,
  input  logic [DATA_WIDTH-1:0] i_cdb_val_1,
  input  logic [DATA_WIDTH-1:0] i_cdb_val_2,
  output logic [ENT_NUM-1:0]    o_busy_vec,
  output logic [ENT_NUM-1:0]    o_vld_vec,
  input  logic                  i_issue_vld,
  input  logic [ENT_SEL-1:0]    i_issue_sel,
  output logic [OP_WIDTH-1:0]   o_issue_op,
  output logic [DATA_WIDTH-1:0] o_issue_srca,
  output logic [DATA_WIDTH-1:0] o_issue_srcb,
  output logic                  o_err
);

  logic [ENT_NUM-1:0]      r_busy;
  logic [OP_WIDTH-1:0]     r_op [ENT_NUM];
  logic                    r_err;

  logic [DP_NUM_WIDTH-1:0] w_we_ok;
  logic                    w_same_sel;
  logic                    w_err_set;
  logic [ENT_NUM-1:0]      w_load;
  logic [ENT_NUM-1:0]      w_load_1;
  logic [ENT_NUM-1:0]      w_vld;
  logic [ENT_NUM-1:0]      w_issue_clr;
  logic [ENT_NUM-1:0]      w_srca_rdy;
  logic [ENT_NUM-1:0]      w_srcb_rdy;
  logic [DATA_WIDTH-1:0]   w_srca_val [ENT_NUM];
  logic [DATA_WIDTH-1:0]   w_srcb_val [ENT_NUM];

  // Write legality: a write is dropped if its target is occupied or if both
  // ports aim at the same entry (then neither port is honoured).
  always_comb begin
    w_same_sel = i_we_1 && i_we_2 && (i_wsel_1 == i_wsel_2);
    w_we_ok[0] = i_we_1 && !r_busy[i_wsel_1] && !w_same_sel;
    w_we_ok[1] = i_we_2 && !r_busy[i_wsel_2] && !w_same_sel;
    w_err_set  = w_same_sel || (i_we_1 && r_busy[i_wsel_1]) ||
                 (i_we_2 && r_busy[i_wsel_2]);
  end

  generate
    for (genvar g = 0; g < ENT_NUM; g++) begin : g_ent
      assign w_load_1[g]    = w_we_ok[0] && (i_wsel_1 == ENT_SEL'(g));
      assign w_load[g]      = w_load_1[g] ||
                              (w_we_ok[1] && (i_wsel_2 == ENT_SEL'(g)));
      // Ready status comes from registered state only.
      assign w_vld[g]       = r_busy[g] && w_srca_rdy[g] && w_srcb_rdy[g];
      assign w_issue_clr[g] = i_issue_vld && (i_issue_sel == ENT_SEL'(g)) &&
                              w_vld[g];

      rs_src_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
      ) u_srca (
        .clk         (clk),
        .rst         (rst),
        .i_kill      (i_kill),
        .i_clr       (w_issue_clr[g]),
        .i_load      (w_load[g]),
        .i_busy      (r_busy[g]),
        .i_ld_rdy    (w_load_1[g] ? i_srca_rdy_1 : i_srca_rdy_2),
        .i_ld_tag    (w_load_1[g] ? i_srca_tag_1 : i_srca_tag_2),
        .i_ld_val    (w_load_1[g] ? i_srca_val_1 : i_srca_val_2),
        .i_cdb_vld_1 (i_cdb_vld_1),
        .i_cdb_tag_1 (i_cdb_tag_1),
        .i_cdb_val_1 (i_cdb_val_1),
        .i_cdb_vld_2 (i_cdb_vld_2),
        .i_cdb_tag_2 (i_cdb_tag_2),
        .i_cdb_val_2 (i_cdb_val_2),
        .o_rdy       (w_srca_rdy[g]),
        .o_val       (w_srca_val[g])
      );

      rs_src_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
      ) u_srcb (
        .clk         (clk),
        .rst         (rst),
        .i_kill      (i_kill),
        .i_clr       (w_issue_clr[g]),
        .i_load      (w_load[g]),
        .i_busy      (r_busy[g]),
        .i_ld_rdy    (w_load_1[g] ? i_srcb_rdy_1 : i_srcb_rdy_2),
        .i_ld_tag    (w_load_1[g] ? i_srcb_tag_1 : i_srcb_tag_2),
        .i_ld_val    (w_load_1[g] ? i_srcb_val_1 : i_srcb_val_2),
        .i_cdb_vld_1 (i_cdb_vld_1),
        .i_cdb_tag_1 (i_cdb_tag_1),
        .i_cdb_val_1 (i_cdb_val_1),
        .i_cdb_vld_2 (i_cdb_vld_2),
        .i_cdb_tag_2 (i_cdb_tag_2),
        .i_cdb_val_2 (i_cdb_val_2),
        .o_rdy       (w_srcb_rdy[g]),
        .o_val       (w_srcb_val[g])
      );
    end
  endgenerate

  // Occupancy and payload: kill clears everything, a legal write fills an
  // entry, and issuing a ready entry frees it for reallocation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      for (int i = 0; i < ENT_NUM; i++) begin
        r_op[i] <= '0;
      end
    end else if (i_kill) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < ENT_NUM; i++) begin
        if (w_load[i]) begin
          r_busy[i] <= 1'b1;
          r_op[i]   <= w_load_1[i] ? i_op_1 : i_op_2;
        end else if (w_issue_clr[i]) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky illegal-write flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign o_busy_vec   = r_busy;
  assign o_vld_vec    = w_vld;
  assign o_err        = r_err;
  assign o_issue_op   = r_op[i_issue_sel];
  assign o_issue_srca = w_srca_val[i_issue_sel];
  assign o_issue_srcb = w_srcb_val[i_issue_sel];

endmodule
`default_nettype wire

// File: tb/tb_rs_inorder_entries.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_inorder_entries
// Purpose  : Scoreboard bench for rs_inorder_entries. A reference model of
//            the entry table predicts every cycle's outputs; a monitor pops
//            the predictions and compares them with the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_inorder_entries;

  localparam int ENT_NUM = 2;
  localparam int ENT_SEL = 1;
  localparam int DW      = 32;
  localparam int TW      = 6;
  localparam int OW      = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic kill;
  logic we_1, we_2;
  logic [ENT_SEL-1:0] wsel_1, wsel_2;
  logic [OW-1:0] op_1, op_2;
  logic srca_rdy_1, srca_rdy_2, srcb_rdy_1, srcb_rdy_2;
  logic [DW-1:0] srca_val_1, srca_val_2, srcb_val_1, srcb_val_2;
  logic [TW-1:0] srca_tag_1, srca_tag_2, srcb_tag_1, srcb_tag_2;
  logic cdb_vld_1, cdb_vld_2;
  logic [TW-1:0] cdb_tag_1, cdb_tag_2;
  logic [DW-1:0] cdb_val_1, cdb_val_2;
  logic issue_vld;
  logic [ENT_SEL-1:0] issue_sel;
  logic [ENT_NUM-1:0] busy_vec, vld_vec;
  logic [OW-1:0] issue_op;
  logic [DW-1:0] issue_srca, issue_srcb;
  logic err;

  always #5 clk = ~clk;

  rs_inorder_entries #(
    .ENT_NUM(ENT_NUM), .ENT_SEL(ENT_SEL), .DATA_WIDTH(DW),
    .TAG_WIDTH(TW), .OP_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst), .i_kill(kill),
    .i_we_1(we_1), .i_we_2(we_2), .i_wsel_1(wsel_1), .i_wsel_2(wsel_2),
    .i_op_1(op_1), .i_op_2(op_2),
    .i_srca_rdy_1(srca_rdy_1), .i_srca_rdy_2(srca_rdy_2),
    .i_srcb_rdy_1(srcb_rdy_1), .i_srcb_rdy_2(srcb_rdy_2),
    .i_srca_val_1(srca_val_1), .i_srca_val_2(srca_val_2),
    .i_srcb_val_1(srcb_val_1), .i_srcb_val_2(srcb_val_2),
    .i_srca_tag_1(srca_tag_1), .i_srca_tag_2(srca_tag_2),
    .i_srcb_tag_1(srcb_tag_1), .i_srcb_tag_2(srcb_tag_2),
    .i_cdb_vld_1(cdb_vld_1), .i_cdb_vld_2(cdb_vld_2),
    .i_cdb_tag_1(cdb_tag_1), .i_cdb_tag_2(cdb_tag_2),
    .i_cdb_val_1(cdb_val_1), .i_cdb_val_2(cdb_val_2),
    .o_busy_vec(busy_vec), .o_vld_vec(vld_vec),
    .i_issue_vld(issue_vld), .i_issue_sel(issue_sel),
    .o_issue_op(issue_op), .o_issue_srca(issue_srca), .o_issue_srcb(issue_srcb),
    .o_err(err)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic          rdy;
    logic [TW-1:0] tag;
    logic [DW-1:0] val;
  } src_t;

  typedef struct {
    logic [ENT_NUM-1:0] busy_vec;
    logic [ENT_NUM-1:0] vld_vec;
    logic               err;
    logic               chk_data;
    logic [OW-1:0]      op;
    logic [DW-1:0]      a;
    logic [DW-1:0]      b;
  } exp_t;

  exp_t          exp_q[$];
  logic          m_busy [ENT_NUM];
  logic [OW-1:0] m_op   [ENT_NUM];
  src_t          m_a    [ENT_NUM];
  src_t          m_b    [ENT_NUM];
  logic          m_err;

  int checks = 0;
  int errors = 0;

  function automatic void model_reset();
    for (int i = 0; i < ENT_NUM; i++) begin
      m_busy[i] = 1'b0;
      m_op[i]   = '0;
      m_a[i]    = '{rdy: 1'b0, tag: '0, val: '0};
      m_b[i]    = '{rdy: 1'b0, tag: '0, val: '0};
    end
    m_err = 1'b0;
  endfunction

  // A waiting operand picks up a matching broadcast; port 1 has precedence.
  function automatic src_t listen(src_t s);
    src_t r = s;
    if (!r.rdy) begin
      if (cdb_vld_1 && cdb_tag_1 == r.tag) begin
        r.rdy = 1'b1; r.val = cdb_val_1;
      end else if (cdb_vld_2 && cdb_tag_2 == r.tag) begin
        r.rdy = 1'b1; r.val = cdb_val_2;
      end
    end
    return r;
  endfunction

  function automatic src_t mk_src(logic rdy, logic [TW-1:0] tag, logic [DW-1:0] val);
    src_t s;
    s.rdy = rdy; s.tag = tag; s.val = val;
    return listen(s);
  endfunction

  // Predict this cycle's outputs, queue them, then advance the model by one edge.
  function automatic void commit();
    exp_t          e;
    logic          nbusy [ENT_NUM];
    logic [OW-1:0] nop   [ENT_NUM];
    src_t          na    [ENT_NUM];
    src_t          nb    [ENT_NUM];
    logic          same, ok1, ok2;
    int            s;
    for (int i = 0; i < ENT_NUM; i++) begin
      e.busy_vec[i] = m_busy[i];
      e.vld_vec[i]  = m_busy[i] && m_a[i].rdy && m_b[i].rdy;
    end
    e.err      = m_err;
    s          = int'(issue_sel);
    e.chk_data = e.vld_vec[s];
    e.op       = m_op[s];
    e.a        = m_a[s].val;
    e.b        = m_b[s].val;
    exp_q.push_back(e);

    nbusy = m_busy; nop = m_op; na = m_a; nb = m_b;
    same = we_1 && we_2 && (wsel_1 == wsel_2);
    if (same || (we_1 && m_busy[wsel_1]) || (we_2 && m_busy[wsel_2])) m_err = 1'b1;
    if (kill) begin
      for (int i = 0; i < ENT_NUM; i++) begin
        nbusy[i] = 1'b0; na[i].rdy = 1'b0; nb[i].rdy = 1'b0;
      end
    end else begin
      for (int i = 0; i < ENT_NUM; i++) begin
        if (m_busy[i]) begin
          na[i] = listen(m_a[i]);
          nb[i] = listen(m_b[i]);
        end
      end
      if (issue_vld && e.vld_vec[s]) begin
        nbusy[s] = 1'b0; na[s].rdy = 1'b0; nb[s].rdy = 1'b0;
      end
      ok1 = we_1 && !m_busy[wsel_1] && !same;
      ok2 = we_2 && !m_busy[wsel_2] && !same;
      if (ok1) begin
        nbusy[wsel_1] = 1'b1; nop[wsel_1] = op_1;
        na[wsel_1] = mk_src(srca_rdy_1, srca_tag_1, srca_val_1);
        nb[wsel_1] = mk_src(srcb_rdy_1, srcb_tag_1, srcb_val_1);
      end
      if (ok2) begin
        nbusy[wsel_2] = 1'b1; nop[wsel_2] = op_2;
        na[wsel_2] = mk_src(srca_rdy_2, srca_tag_2, srca_val_2);
        nb[wsel_2] = mk_src(srcb_rdy_2, srcb_tag_2, srcb_val_2);
      end
    end
    m_busy = nbusy; m_op = nop; m_a = na; m_b = nb;
  endfunction

  // Expect everything zero while rst is asserted.
  function automatic void push_reset_exp();
    exp_t e;
    e = '{busy_vec: '0, vld_vec: '0, err: 1'b0, chk_data: 1'b1,
          op: '0, a: '0, b: '0};
    exp_q.push_back(e);
  endfunction

  // ---------------- monitor ----------------
  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busy_vec", 32'(busy_vec), 32'(e.busy_vec));
        chk("vld_vec",  32'(vld_vec),  32'(e.vld_vec));
        chk("err",      32'(err),      32'(e.err));
        if (e.chk_data) begin
          chk("issue_op",   32'(issue_op), 32'(e.op));
          chk("issue_srca", issue_srca,    e.a);
          chk("issue_srcb", issue_srcb,    e.b);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    kill = 0; we_1 = 0; we_2 = 0; wsel_1 = 0; wsel_2 = 0; op_1 = 0; op_2 = 0;
    srca_rdy_1 = 0; srca_rdy_2 = 0; srcb_rdy_1 = 0; srcb_rdy_2 = 0;
    srca_val_1 = 0; srca_val_2 = 0; srcb_val_1 = 0; srcb_val_2 = 0;
    srca_tag_1 = 0; srca_tag_2 = 0; srcb_tag_1 = 0; srcb_tag_2 = 0;
    cdb_vld_1 = 0; cdb_vld_2 = 0; cdb_tag_1 = 0; cdb_tag_2 = 0;
    cdb_val_1 = 0; cdb_val_2 = 0; issue_vld = 0; issue_sel = 0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  // Assert rst between clock edges; outputs must drop before the next edge.
  task automatic async_reset_cycle();
    #1 rst = 1'b1;
    model_reset();
    push_reset_exp();
  endtask

  task automatic write1(logic [ENT_SEL-1:0] sel, logic [OW-1:0] op,
                        logic ar, logic [TW-1:0] at, logic [DW-1:0] av,
                        logic br, logic [TW-1:0] bt, logic [DW-1:0] bv);
    we_1 = 1; wsel_1 = sel; op_1 = op;
    srca_rdy_1 = ar; srca_tag_1 = at; srca_val_1 = av;
    srcb_rdy_1 = br; srcb_tag_1 = bt; srcb_val_1 = bv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    push_reset_exp();
    next_cycle(); rst = 1'b0; commit();

    // Dispatch with srcb waiting on tag 5, wake from CDB1, issue.
    next_cycle(); write1(0, 16'h1234, 1, 0, 32'h11, 0, 5, 32'h0); commit();
    next_cycle(); commit();
    next_cycle(); cdb_vld_1 = 1; cdb_tag_1 = 5; cdb_val_1 = 32'h22; commit();
    next_cycle(); issue_vld = 1; issue_sel = 0; commit();
    next_cycle(); commit();

    // Dual write; entry 1 srcb bypasses CDB2 tag 7, entry 0 waits on tag 9.
    next_cycle();
    write1(0, 16'hAAAA, 0, 9, 32'h0, 1, 0, 32'h32);
    we_2 = 1; wsel_2 = 1; op_2 = 16'hBBBB;
    srca_rdy_2 = 1; srca_val_2 = 32'h41;
    srcb_rdy_2 = 0; srcb_tag_2 = 7; srcb_val_2 = 32'hDEAD;
    cdb_vld_2 = 1; cdb_tag_2 = 7; cdb_val_2 = 32'h77;
    commit();
    next_cycle(); issue_vld = 1; issue_sel = 1; commit();
    next_cycle(); cdb_vld_1 = 1; cdb_tag_1 = 9; cdb_val_1 = 32'h99; commit();
    next_cycle(); issue_vld = 1; issue_sel = 0; commit();

    // Both CDB ports carry tag 3; port 1 value must win.
    next_cycle(); write1(0, 16'h0303, 1, 0, 32'h5, 0, 3, 32'h0); commit();
    next_cycle();
    cdb_vld_1 = 1; cdb_tag_1 = 3; cdb_val_1 = 32'hA;
    cdb_vld_2 = 1; cdb_tag_2 = 3; cdb_val_2 = 32'hB;
    commit();
    next_cycle(); issue_vld = 1; issue_sel = 0; commit();

    // Write to a busy entry: ignored, sticky error.
    next_cycle(); write1(1, 16'h4444, 1, 0, 32'h1, 1, 0, 32'h2); commit();
    next_cycle(); write1(1, 16'h5555, 1, 0, 32'h9, 1, 0, 32'h9); commit();
    next_cycle(); issue_sel = 1; commit();
    next_cycle(); issue_sel = 1; commit();

    // Kill together with a write to entry 0 and issue of entry 1.
    next_cycle();
    kill = 1; write1(0, 16'h6666, 1, 0, 32'h6, 1, 0, 32'h6);
    issue_vld = 1; issue_sel = 1;
    commit();
    next_cycle(); commit();

    // Fill both entries, then assert rst asynchronously mid-cycle.
    next_cycle();
    write1(0, 16'h7070, 1, 0, 32'h70, 1, 0, 32'h71);
    we_2 = 1; wsel_2 = 1; op_2 = 16'h8080;
    srca_rdy_2 = 1; srca_val_2 = 32'h80; srcb_rdy_2 = 1; srcb_val_2 = 32'h81;
    commit();
    next_cycle(); commit();
    next_cycle(); async_reset_cycle();
    next_cycle(); rst = 1'b0; commit();

    // Randomized traffic with a small tag space so wakeups collide often.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      if (rst) rst = 1'b0;
      if ($urandom_range(0, 249) == 0) begin
        async_reset_cycle();
        continue;
      end
      we_1 = 1'($urandom_range(0, 1));  we_2 = 1'($urandom_range(0, 1));
      wsel_1 = ENT_SEL'($urandom);      wsel_2 = ENT_SEL'($urandom);
      op_1 = OW'($urandom);             op_2 = OW'($urandom);
      srca_rdy_1 = 1'($urandom_range(0, 1)); srcb_rdy_1 = 1'($urandom_range(0, 1));
      srca_rdy_2 = 1'($urandom_range(0, 1)); srcb_rdy_2 = 1'($urandom_range(0, 1));
      srca_val_1 = $urandom; srcb_val_1 = $urandom;
      srca_val_2 = $urandom; srcb_val_2 = $urandom;
      srca_tag_1 = TW'($urandom_range(0, 7)); srcb_tag_1 = TW'($urandom_range(0, 7));
      srca_tag_2 = TW'($urandom_range(0, 7)); srcb_tag_2 = TW'($urandom_range(0, 7));
      cdb_vld_1 = 1'($urandom_range(0, 1)); cdb_vld_2 = 1'($urandom_range(0, 1));
      cdb_tag_1 = TW'($urandom_range(0, 7)); cdb_tag_2 = TW'($urandom_range(0, 7));
      cdb_val_1 = $urandom; cdb_val_2 = $urandom;
      issue_vld = 1'($urandom_range(0, 1));
      issue_sel = ENT_SEL'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        kill = 1; we_1 = 0; we_2 = 0;
      end
      commit();
    end

    next_cycle(); rst = 1'b0; commit();
    @(negedge clk);
    #5;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
